board_writer: RTL and testbench

Owns the 20x12 Tetris playfield and is the writer for the 240-bit board vector that the VGA pattern generator reads.
- Accepts cell-set, cell-clear, row-clear and board-clear commands over a valid/ready handshake.
- Edits a working copy of the board.
- Publishes the working copy to the display vector only at the start of vertical blanking, so the pattern generator never shows a half-updated frame.

---
 rtl/tetris_pkg.sv | 19 +
 rtl/row_full_detect.sv | 13 +
 rtl/board_writer.sv | 162 ++++++++++++++++
 tb/tb_board_writer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield geometry, command encodings, FSM states and row addressing for the Tetris board logic.
package tetris_pkg;

  localparam int ROWS_DEF = 20;
  localparam int COLS_DEF = 12;

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_CLR    = 2'b01;
  localparam logic [1:0] OP_ROWCLR = 2'b10;
  localparam logic [1:0] OP_BRDCLR = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, SCAN, SHIFT} state_t;

  // Row 0 is the top row and lives in the most significant COLS bits.
  function automatic int row_offset(input int rows, input int cols, input int r);
    return (rows - 1 - r) * cols;
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// Flags a playfield row whose every cell is occupied; purely combinational.
import tetris_pkg::*;

module row_full_detect #(
  parameter int COLS = COLS_DEF
) (
  input  logic [COLS-1:0] row,
  output logic            full
);

  assign full = &row;

endmodule

// File: rtl/board_writer.sv
// Edits a working Tetris playfield from commands and publishes it at vblank start; BOARD_WRITER_TOTAL_EN adds a lines_total accumulator.
// Latency: set/clear/board-clear done two edges after transfer; row-clear scans bottom-up, shifting rows down as full ones are found.
// Backpressure: cmd_ready only in IDLE with no queue; commands wait at the source while busy.
import tetris_pkg::*;

module board_writer #(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [4:0]           cmd_row,
  input  logic [3:0]           cmd_col,
  input  logic                 vblank,
  output logic [ROWS*COLS-1:0] board,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           lines_cleared,
  output logic [15:0]          lines_total
);

  localparam int NB = ROWS * COLS;
  localparam int IW = $clog2(NB);

  state_t          state, state_nxt;
  logic [NB-1:0]   work;
  logic [1:0]      op_q;
  logic [4:0]      row_q;
  logic [3:0]      col_q;
  logic [4:0]      ptr;
  logic [4:0]      k;
  logic [2:0]      cnt;
  logic            vblank_d;
  logic            pending;
  logic            xfer;
  logic            row_full;
  logic            cell_ok;
  logic            scan_done;
  logic            vb_rise;
  logic            publish_now;
  logic [COLS-1:0] scan_row;
  logic [IW-1:0]   cell_idx;
  logic [IW-1:0]   ptr_off;
  logic [IW-1:0]   k_off;
  logic [IW-1:0]   km1_off;

  assign xfer     = cmd_valid && cmd_ready;
  assign cell_ok  = (row_q < 5'(ROWS)) && (col_q < 4'(COLS));
  assign cell_idx = IW'(row_offset(ROWS, COLS, int'(row_q)) + COLS - 1 - int'(col_q));
  assign ptr_off  = IW'(row_offset(ROWS, COLS, int'(ptr)));
  assign k_off    = IW'(row_offset(ROWS, COLS, int'(k)));
  assign km1_off  = IW'(row_offset(ROWS, COLS, int'(k) - 1));
  assign scan_row = work[ptr_off +: COLS];

  row_full_detect #(.COLS(COLS)) u_row_full (
    .row  (scan_row),
    .full (row_full)
  );

  assign scan_done   = (state == SCAN) && !row_full && (ptr == '0);
  assign vb_rise     = vblank && !vblank_d;
  // A rise missed while busy is honoured on the first IDLE cycle of the same blanking interval.
  assign publish_now = vblank && (state == IDLE) && (vb_rise || pending);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (xfer) state_nxt = (cmd_op == OP_ROWCLR) ? SCAN : EXEC;
      EXEC:  state_nxt = IDLE;
      SCAN:  if (row_full) state_nxt = SHIFT;
             else if (ptr == '0) state_nxt = IDLE;
      SHIFT: if (k == '0) state_nxt = SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work          <= '0;
      board         <= '0;
      op_q          <= OP_SET;
      row_q         <= '0;
      col_q         <= '0;
      ptr           <= '0;
      k             <= '0;
      cnt           <= '0;
      vblank_d      <= 1'b0;
      pending       <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
    end else begin
      vblank_d <= vblank;
      done     <= 1'b0;
      if (publish_now) board <= work;
      if (!vblank || publish_now)       pending <= 1'b0;
      else if (vb_rise && state != IDLE) pending <= 1'b1;

      unique case (state)
        IDLE: if (xfer) begin
          op_q  <= cmd_op;
          row_q <= cmd_row;
          col_q <= cmd_col;
          ptr   <= 5'(ROWS - 1);
          cnt   <= '0;
        end
        EXEC: begin
          done <= 1'b1;
          if (op_q == OP_BRDCLR) work <= '0;
          else if ((op_q == OP_SET || op_q == OP_CLR) && cell_ok) work[cell_idx] <= (op_q == OP_SET);
        end
        SCAN: begin
          if (row_full) begin
            k <= ptr;
            if (cnt != 3'd7) cnt <= cnt + 3'd1;
          end else if (ptr == '0) begin
            done          <= 1'b1;
            lines_cleared <= cnt;
          end else begin
            ptr <= ptr - 5'd1;
          end
        end
        SHIFT: begin
          // Pointer stays put: the row pulled down must be re-tested.
          if (k == '0) work[k_off +: COLS] <= '0;
          else         work[k_off +: COLS] <= work[km1_off +: COLS];
          k <= k - 5'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef BOARD_WRITER_TOTAL_EN
  logic [15:0] total_q;
  logic [16:0] total_sum;

  assign total_sum = {1'b0, total_q} + 17'(cnt);

  always_ff @(posedge clk) begin
    if (rst)            total_q <= '0;
    else if (scan_done) total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
  end

  assign lines_total = total_q;
`else
  assign lines_total = '0;
`endif

endmodule

// File: tb/tb_board_writer.sv
// Randomized and directed bench for board_writer against a row-compaction reference model of the playfield.
module tb_board_writer;

  localparam int ROWS = 20;
  localparam int COLS = 12;
  localparam int NB   = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [4:0]    cmd_row;
  logic [3:0]    cmd_col;
  logic          vblank;
  logic [NB-1:0] board;
  logic          busy;
  logic          done;
  logic [2:0]    lines_cleared;
  logic [15:0]   lines_total;

  int n_checks = 0;
  int n_fail   = 0;

  bit            mw [ROWS][COLS];
  logic [NB-1:0] mboard;
  int            mtotal;

  always #5 clk = ~clk;

  board_writer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_row       (cmd_row),
    .cmd_col       (cmd_col),
    .vblank        (vblank),
    .board         (board),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .lines_total   (lines_total)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] pack_work();
    logic [NB-1:0] v;
    v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[(ROWS-1-r)*COLS + (COLS-1-c)] = mw[r][c];
    return v;
  endfunction

  function automatic void model_clear_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mw[r][c] = 1'b0;
  endfunction

  // Drop every full row and let the survivors fall, keeping their order.
  function automatic int model_rowclear();
    bit nw [ROWS][COLS];
    int dst;
    int cleared;
    dst = ROWS - 1;
    cleared = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        nw[r][c] = 1'b0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      bit full;
      full = 1'b1;
      for (int c = 0; c < COLS; c++) full &= mw[r][c];
      if (full) cleared++;
      else begin
        for (int c = 0; c < COLS; c++) nw[dst][c] = mw[r][c];
        dst--;
      end
    end
    mw = nw;
    return cleared;
  endfunction

  // vb_mode 1: raise vblank right after transfer; 2: raise it and drop it a few cycles later.
  task automatic send(input logic [1:0] op, input int row, input int col, input int vb_mode, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = row[4:0];
    cmd_col   = col[3:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    if (vb_mode != 0) vblank = 1'b1;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (vb_mode == 2 && lat == 4) vblank = 1'b0;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic after_done();
    @(negedge clk);
    check("done_width", done, 0);
    check("busy_idle", busy, 0);
    check("ready_back", cmd_ready, 1);
  endtask

  task automatic run(input logic [1:0] op, input int row, input int col, input int vb_mode);
    int lat;
    int cnt;
    send(op, row, col, vb_mode, lat);
    if (op == 2'b10) begin
      cnt = model_rowclear();
      if (cnt > 7) cnt = 7;
      check("lines_cleared", lines_cleared, cnt);
`ifdef BOARD_WRITER_TOTAL_EN
      mtotal = mtotal + cnt;
      if (mtotal > 65535) mtotal = 65535;
`endif
      check("lines_total", lines_total, mtotal);
    end else begin
      check("exec_latency", lat, 2);
      if (op == 2'b11) model_clear_all();
      else if (row < ROWS && col < COLS) mw[row][col] = (op == 2'b00);
    end
    if (vb_mode == 0) after_done();
  endtask

  task automatic fill_row(input int r);
    for (int c = 0; c < COLS; c++) run(2'b00, r, c, 0);
  endtask

  task automatic publish(input string tag);
    vblank = 1'b1;
    @(negedge clk);
    mboard = pack_work();
    check(tag, board, mboard);
    vblank = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, limit 900000 ns");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] one;
    logic [NB-1:0] exp3;
    logic [NB-1:0] old;
    int            lat;
    int            exp_total;
    int            r;
    one  = 1;
    exp3 = 'h910;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0; cmd_col = '0; vblank = 1'b0;
    model_clear_all();
    mboard = '0;
    mtotal = 0;

    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_board", board, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_total", lines_total, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    // Out-of-range cells still complete but leave the board alone.
    run(2'b00, 20, 3, 0);
    run(2'b00, 4, 12, 0);
    publish("tp4_board");
    check("tp4_zero", board, 0);

    run(2'b00, 19, 0, 0);
    check("tp1_pre_vblank", board, 0);
    publish("tp1_board");
    check("tp1_bit11", board, one << 11);

    fill_row(18);
    fill_row(19);
    run(2'b00, 17, 5, 0);
    run(2'b10, 0, 0, 0);
    check("tp2_cleared", lines_cleared, 2);
    publish("tp2_board");
    check("tp2_bit6", board, one << 6);

    run(2'b11, 0, 0, 0);
    fill_row(19);
    fill_row(17);
    run(2'b00, 18, 0, 0);
    run(2'b00, 18, 3, 0);
    run(2'b00, 18, 7, 0);
    run(2'b10, 0, 0, 0);
    check("tp3_cleared", lines_cleared, 2);
    publish("tp3_board");
    check("tp3_pattern", board, exp3);

    // Publish deferred until the op finishes while vblank stays high.
    fill_row(19);
    run(2'b00, 10, 4, 0);
    publish("tp5_pre");
    old = board;
    run(2'b10, 0, 0, 1);
    check("tp5_hold_busy", board, old);
    after_done();
    check("tp5_pending_pub", board, pack_work());
    mboard = pack_work();
    vblank = 1'b0;
    @(negedge clk);
    fill_row(19);
    publish("tp5b_pre");
    old = board;
    run(2'b10, 0, 0, 2);
    after_done();
    repeat (3) @(negedge clk);
    check("tp5b_no_pub", board, old);
    publish("tp5b_next_frame");

    fill_row(19);
    publish("tp6_pre");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_row = '0; cmd_col = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("tp6_busy_shift", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("tp6_board", board, 0);
    check("tp6_busy", busy, 0);
    check("tp6_done", done, 0);
    check("tp6_ready_in_rst", cmd_ready, 0);
    rst = 1'b0;
    model_clear_all();
    mboard = '0;
    mtotal = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tp6_no_done", done, 0);
    end
    publish("tp6_work_cleared");

    fill_row(19);
    run(2'b10, 0, 0, 0);
    for (int rr = 16; rr < 20; rr++) fill_row(rr);
    run(2'b10, 0, 0, 0);
    run(2'b10, 0, 0, 0);
`ifdef BOARD_WRITER_TOTAL_EN
    exp_total = 5;
`else
    exp_total = 0;
`endif
    check("total_1_4_0", lines_total, exp_total);

    for (int rr = 12; rr < 20; rr++) fill_row(rr);
    run(2'b10, 0, 0, 0);
    check("cleared_sat7", lines_cleared, 7);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      run(2'b00, $urandom_range(0, 21), $urandom_range(0, 13), 0);
      else if (r < 55) run(2'b01, $urandom_range(0, 21), $urandom_range(0, 13), 0);
      else if (r < 65) fill_row($urandom_range(14, 19));
      else if (r < 80) run(2'b10, 0, 0, 0);
      else if (r < 83) run(2'b11, 0, 0, 0);
      else begin
        check("rand_board_stable", board, mboard);
        publish("rand_publish");
      end
    end
    publish("final_publish");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
